// File: rtl/header_ram_ctrl.sv
// Event-framed circular-buffer controller for a dual-port header RAM.
// Whole events are committed on their last word and read out as an unthrottled word stream.
module header_ram_ctrl #(
    parameter int DATA_WIDTH = 17,
    parameter int RAM_ADRB   = 11
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  hdr_wr_en,
    input  logic [DATA_WIDTH-1:0] hdr_wr_data,
    input  logic                  hdr_wr_last,
    input  logic                  rd_req,
    output logic                  rd_busy,
    output logic                  rd_data_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_last,
    output logic [RAM_ADRB:0]     evt_count,
    output logic [RAM_ADRB:0]     words_used,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic                  ram_wr_wea,
    output logic [RAM_ADRB-1:0]   ram_wr_adra,
    output logic [DATA_WIDTH:0]   ram_wr_dataa,
    output logic                  ram_rd_enb,
    output logic [RAM_ADRB-1:0]   ram_rd_adrb,
    input  logic [DATA_WIDTH:0]   ram_rd_datab
);

    localparam int PW = RAM_ADRB + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {RAM_ADRB{1'b0}}};

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} wstate_t;
    typedef enum logic       {R_IDLE, R_STREAM}          rstate_t;

    wstate_t               wstate_q, wstate_d;
    rstate_t               rstate_q, rstate_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         cptr_q, cptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         evt_q, evt_d;
    logic                  ovf_q, ovf_d;
    logic                  enb_q, enb_d;
    logic [RAM_ADRB-1:0]   adrb_q, adrb_d;
    logic                  vld_q, vld_d;

    logic full, wr_live, wr_accept, wr_overflow, commit, rd_last_word;

    // Pointers carry one extra wrap bit so a completely full buffer reads DEPTH.
    assign words_used   = wptr_q - rptr_q;
    assign rd_last_word = vld_q & ram_rd_datab[DATA_WIDTH];
    // The word leaving on the read side this cycle frees its slot for the writer now.
    assign full         = (words_used == DEPTH) && !vld_q;
    assign wr_live      = hdr_wr_en && (wstate_q != W_DISCARD);
    assign wr_accept    = wr_live && !full;
    assign wr_overflow  = wr_live && full;
    assign commit       = wr_accept && hdr_wr_last;

    assign ram_wr_wea   = wr_accept;
    assign ram_wr_adra  = wptr_q[RAM_ADRB-1:0];
    assign ram_wr_dataa = {hdr_wr_last, hdr_wr_data};
    assign ram_rd_enb   = enb_q;
    assign ram_rd_adrb  = adrb_q;

    assign rd_busy      = (rstate_q == R_STREAM);
    assign rd_data_vld  = vld_q;
    assign rd_data      = ram_rd_datab[DATA_WIDTH-1:0];
    assign rd_data_last = ram_rd_datab[DATA_WIDTH];
    assign evt_count    = evt_q;
    assign ovf          = ovf_q;

    always_comb begin
        wstate_d = wstate_q;
        wptr_d   = wptr_q;
        cptr_d   = cptr_q;
        ovf_d    = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_accept) begin
            wptr_d = wptr_q + PW'(1);
            if (hdr_wr_last) begin
                cptr_d   = wptr_q + PW'(1);
                wstate_d = W_IDLE;
            end else begin
                wstate_d = W_FILL;
            end
        end else if (wr_overflow) begin
            wptr_d   = cptr_q;
            ovf_d    = 1'b1;
            wstate_d = hdr_wr_last ? W_IDLE : W_DISCARD;
        end else if (hdr_wr_en && hdr_wr_last && wstate_q == W_DISCARD) begin
            wstate_d = W_IDLE;
        end
    end

    always_comb begin
        evt_d = evt_q;
        case ({commit, rd_last_word})
            2'b10:   evt_d = evt_q + PW'(1);
            2'b01:   evt_d = evt_q - PW'(1);
            default: evt_d = evt_q;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        enb_d    = enb_q;
        adrb_d   = adrb_q;
        vld_d    = 1'b0;
        rptr_d   = rptr_q + PW'(vld_q);
        case (rstate_q)
            R_IDLE: begin
                if (rd_req && evt_q != '0) begin
                    rstate_d = R_STREAM;
                    enb_d    = 1'b1;
                    adrb_d   = rptr_q[RAM_ADRB-1:0];
                end
            end
            R_STREAM: begin
                // One speculative read past the last word is issued and simply never flagged valid.
                adrb_d = adrb_q + RAM_ADRB'(1);
                vld_d  = enb_q;
                if (rd_last_word) begin
                    rstate_d = R_IDLE;
                    enb_d    = 1'b0;
                    vld_d    = 1'b0;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            wptr_q   <= '0;
            cptr_q   <= '0;
            rptr_q   <= '0;
            evt_q    <= '0;
            ovf_q    <= 1'b0;
            enb_q    <= 1'b0;
            adrb_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            wptr_q   <= wptr_d;
            cptr_q   <= cptr_d;
            rptr_q   <= rptr_d;
            evt_q    <= evt_d;
            ovf_q    <= ovf_d;
            enb_q    <= enb_d;
            adrb_q   <= adrb_d;
            vld_q    <= vld_d;
        end
    end

endmodule

// File: tb/tb_header_ram_ctrl.sv
// Directed bench for header_ram_ctrl with a 16-word READ_FIRST RAM model.
module tb_header_ram_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        hdr_wr_en = 1'b0;
    logic [16:0] hdr_wr_data = '0;
    logic        hdr_wr_last = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_busy, rd_data_vld, rd_data_last, ovf;
    logic        ovf_clr = 1'b0;
    logic [16:0] rd_data;
    logic [4:0]  evt_count, words_used;
    logic        ram_wr_wea, ram_rd_enb;
    logic [3:0]  ram_wr_adra, ram_rd_adrb;
    logic [17:0] ram_wr_dataa;
    logic [17:0] ram_rd_datab = '0;
    logic [17:0] mem [0:15];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    header_ram_ctrl #(.DATA_WIDTH(17), .RAM_ADRB(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .hdr_wr_en(hdr_wr_en), .hdr_wr_data(hdr_wr_data), .hdr_wr_last(hdr_wr_last),
        .rd_req(rd_req), .rd_busy(rd_busy), .rd_data_vld(rd_data_vld),
        .rd_data(rd_data), .rd_data_last(rd_data_last),
        .evt_count(evt_count), .words_used(words_used),
        .ovf(ovf), .ovf_clr(ovf_clr),
        .ram_wr_wea(ram_wr_wea), .ram_wr_adra(ram_wr_adra), .ram_wr_dataa(ram_wr_dataa),
        .ram_rd_enb(ram_rd_enb), .ram_rd_adrb(ram_rd_adrb), .ram_rd_datab(ram_rd_datab)
    );

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
    end

    // Non-blocking read and write in one process give READ_FIRST behaviour.
    always @(posedge clock) begin
        if (ram_wr_wea) mem[ram_wr_adra] <= ram_wr_dataa;
        if (ram_rd_enb) ram_rd_datab <= mem[ram_rd_adrb];
    end

    function automatic logic [16:0] dv(input int ev, input int idx);
        return 17'h10000 | 17'(ev * 16 + idx);
    endfunction

    task automatic wr(input logic [16:0] d, input logic l);
        hdr_wr_en = 1'b1; hdr_wr_data = d; hdr_wr_last = l;
        @(negedge clock);
        hdr_wr_en = 1'b0; hdr_wr_last = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic read_event(input int ev, input int n);
        int cnt;
        rd_req = 1'b1;
        @(negedge clock);
        rd_req = 1'b0;
        cnt = 0;
        while (!rd_data_vld && cnt < 8) begin
            @(negedge clock);
            cnt++;
        end
        n_cmp++;
        if (rd_data_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_timeout ev=%0d: rd_data_vld=%b required 1 within 8 cycles", ev, rd_data_vld);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_cmp++;
                if (rd_data_vld !== 1'b1 || rd_data !== dv(ev, i) || rd_data_last !== (i == n - 1)) begin
                    n_bad++;
                    $display("FAIL rd_word ev=%0d i=%0d: vld=%b data=%h last=%b required vld=1 data=%h last=%b",
                             ev, i, rd_data_vld, rd_data, rd_data_last, dv(ev, i), (i == n - 1));
                end
                @(negedge clock);
            end
            n_cmp++;
            if (rd_data_vld !== 1'b0 || rd_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rd_end ev=%0d: vld=%b busy=%b required 0 0", ev, rd_data_vld, rd_busy);
            end
        end
        $display("read event %0d (%0d words) latency %0d", ev, n, cnt);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (evt_count !== 5'd0 || words_used !== 5'd0 || ovf !== 1'b0 || rd_busy !== 1'b0 ||
            rd_data_vld !== 1'b0 || ram_rd_enb !== 1'b0 || ram_wr_wea !== 1'b0 || ram_wr_adra !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_state: evt=%0d used=%0d ovf=%b busy=%b vld=%b enb=%b wea=%b adra=%0d required all 0",
                     evt_count, words_used, ovf, rd_busy, rd_data_vld, ram_rd_enb, ram_wr_wea, ram_wr_adra);
        end
        $display("reset checked");
    endtask

    task automatic test_basic();
        logic [16:0] exp_d [3];
        exp_d[0] = 17'h1A; exp_d[1] = 17'h1B; exp_d[2] = 17'h1C;
        hdr_wr_en = 1'b1; hdr_wr_data = 17'h1A; hdr_wr_last = 1'b0;
        #1;
        n_cmp++;
        if (ram_wr_wea !== 1'b1 || ram_wr_adra !== 4'd0 || ram_wr_dataa !== 18'h0001A) begin
            n_bad++;
            $display("FAIL port_a: wea=%b adra=%0d dataa=%h required 1 0 0001a", ram_wr_wea, ram_wr_adra, ram_wr_dataa);
        end
        @(negedge clock);
        hdr_wr_en = 1'b0;
        wr(17'h1B, 1'b0);
        wr(17'h1C, 1'b1);
        n_cmp++;
        if (evt_count !== 5'd1 || words_used !== 5'd3) begin
            n_bad++;
            $display("FAIL basic_commit: evt=%0d used=%0d required 1 3", evt_count, words_used);
        end
        rd_req = 1'b1;
        @(negedge clock);
        rd_req = 1'b0;
        n_cmp++;
        if (ram_rd_enb !== 1'b1 || ram_rd_adrb !== 4'd0 || rd_busy !== 1'b1 || rd_data_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_t1: enb=%b adrb=%0d busy=%b vld=%b required 1 0 1 0",
                     ram_rd_enb, ram_rd_adrb, rd_busy, rd_data_vld);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if (rd_data_vld !== 1'b1 || rd_data !== exp_d[i] || rd_data_last !== (i == 2)) begin
                n_bad++;
                $display("FAIL basic_word%0d: vld=%b data=%h last=%b required 1 %h %b",
                         i, rd_data_vld, rd_data, rd_data_last, exp_d[i], (i == 2));
            end
        end
        @(negedge clock);
        n_cmp++;
        if (rd_data_vld !== 1'b0 || rd_busy !== 1'b0 || evt_count !== 5'd0 || words_used !== 5'd0) begin
            n_bad++;
            $display("FAIL basic_done: vld=%b busy=%b evt=%0d used=%0d required 0 0 0 0",
                     rd_data_vld, rd_busy, evt_count, words_used);
        end
        $display("basic event 1A/1B/1C written and read");
    endtask

    task automatic test_empty_req();
        rd_req = 1'b1;
        @(negedge clock);
        rd_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (ram_rd_enb !== 1'b0 || rd_data_vld !== 1'b0 || rd_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL empty_req c%0d: enb=%b vld=%b busy=%b required 0 0 0",
                         i, ram_rd_enb, rd_data_vld, rd_busy);
            end
            @(negedge clock);
        end
        $display("rd_req on empty buffer ignored");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 15; i++) wr(dv(9, i), 1'b0);
        n_cmp++;
        if (words_used !== 5'd15 || evt_count !== 5'd0) begin
            n_bad++;
            $display("FAIL ovf_fill15: used=%0d evt=%0d required 15 0", words_used, evt_count);
        end
        wr(dv(9, 15), 1'b0);
        n_cmp++;
        if (words_used !== 5'd16 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_full: used=%0d ovf=%b required 16 0", words_used, ovf);
        end
        hdr_wr_en = 1'b1; hdr_wr_data = dv(9, 16); hdr_wr_last = 1'b1;
        #1;
        n_cmp++;
        if (ram_wr_wea !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_no_write: wea=%b required 0", ram_wr_wea);
        end
        @(negedge clock);
        hdr_wr_en = 1'b0; hdr_wr_last = 1'b0;
        n_cmp++;
        if (ovf !== 1'b1 || words_used !== 5'd0 || evt_count !== 5'd0) begin
            n_bad++;
            $display("FAIL ovf_rewind: ovf=%b used=%0d evt=%0d required 1 0 0", ovf, words_used, evt_count);
        end
        ovf_clr = 1'b1;
        @(negedge clock);
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clr: ovf=%b required 0", ovf);
        end
        wr(dv(10, 0), 1'b0);
        wr(dv(10, 1), 1'b1);
        read_event(10, 2);
        $display("overflow rewind and clear done");
    endtask

    task automatic test_wrap();
        int exp_addr;
        do_reset();
        exp_addr = 0;
        for (int ev = 0; ev < 5; ev++) begin
            for (int i = 0; i < 5; i++) begin
                hdr_wr_en = 1'b1; hdr_wr_data = dv(ev, i); hdr_wr_last = (i == 4);
                #1;
                n_cmp++;
                if (ram_wr_wea !== 1'b1 || ram_wr_adra !== 4'(exp_addr)) begin
                    n_bad++;
                    $display("FAIL wrap_addr ev=%0d i=%0d: wea=%b adra=%0d required 1 %0d",
                             ev, i, ram_wr_wea, ram_wr_adra, exp_addr % 16);
                end
                @(negedge clock);
                exp_addr++;
            end
            hdr_wr_en = 1'b0; hdr_wr_last = 1'b0;
            n_cmp++;
            if (words_used !== 5'd5 || evt_count !== 5'd1) begin
                n_bad++;
                $display("FAIL wrap_commit ev=%0d: used=%0d evt=%0d required 5 1", ev, words_used, evt_count);
            end
            read_event(ev, 5);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) wr(dv(1, i), (i == 2));
        rd_req = 1'b1;
        @(negedge clock);
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hdr_wr_en = 1'b1; hdr_wr_data = dv(2, i); hdr_wr_last = (i == 3);
            if (i > 0) begin
                n_cmp++;
                if (rd_data_vld !== 1'b1 || rd_data !== dv(1, i - 1) || rd_data_last !== (i == 3)) begin
                    n_bad++;
                    $display("FAIL b2b_A%0d: vld=%b data=%h last=%b required 1 %h %b",
                             i - 1, rd_data_vld, rd_data, rd_data_last, dv(1, i - 1), (i == 3));
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (evt_count !== 5'd1) begin
                    n_bad++;
                    $display("FAIL b2b_pre: evt=%0d required 1", evt_count);
                end
            end
            @(negedge clock);
        end
        hdr_wr_en = 1'b0; hdr_wr_last = 1'b0;
        n_cmp++;
        if (evt_count !== 5'd1 || rd_data_vld !== 1'b0 || words_used !== 5'd4) begin
            n_bad++;
            $display("FAIL b2b_post: evt=%0d vld=%b used=%0d required 1 0 4", evt_count, rd_data_vld, words_used);
        end
        read_event(2, 4);
        n_cmp++;
        if (evt_count !== 5'd0 || words_used !== 5'd0) begin
            n_bad++;
            $display("FAIL b2b_end: evt=%0d used=%0d required 0 0", evt_count, words_used);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 6; i++) wr(dv(7, i), (i == 5));
        rd_req = 1'b1;
        @(negedge clock);
        rd_req = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if (rd_data_vld !== 1'b1 || rd_data !== dv(7, 1)) begin
            n_bad++;
            $display("FAIL mid_stream: vld=%b data=%h required 1 %h", rd_data_vld, rd_data, dv(7, 1));
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (rd_data_vld !== 1'b0 || rd_busy !== 1'b0 || ram_rd_enb !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_abort: vld=%b busy=%b enb=%b required 0 0 0", rd_data_vld, rd_busy, ram_rd_enb);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (evt_count !== 5'd0 || words_used !== 5'd0 || ram_wr_adra !== 4'd0 || ram_rd_adrb !== 4'd0 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_release: evt=%0d used=%0d adra=%0d adrb=%0d ovf=%b required 0 0 0 0 0",
                     evt_count, words_used, ram_wr_adra, ram_rd_adrb, ovf);
        end
        $display("reset during readout checked");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_req();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
